// File: rtl/enemy_wave_scheduler.sv
// enemy_wave_scheduler: spawn pulses, round-robin dive selection, wave sequencing and kill counting for the enemy pool.
// Latency: every output is registered; a spawn/dive decision taken on the timer terminal frame appears on the next frame.
// Backpressure: none; a spawn attempt with no free slot is dropped until the next gap. Build macro SPAWN_ACCEL_EN shortens the spawn gap per wave.
module enemy_wave_scheduler #(
    parameter int         NUM_ENEMIES = 4,
    parameter int         WAVE_SIZE   = 8,
    parameter int         SPAWN_GAP   = 32,
    parameter int         DIVE_PERIOD = 120,
    parameter int         CLEAR_PAUSE = 60,
    parameter int         NUM_ROWS    = 4,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   start,
    input  logic                   player_dead,
    input  logic [NUM_ENEMIES-1:0] enemy_exists,
    input  logic [NUM_ENEMIES-1:0] enemy_explosion,
    output logic [NUM_ENEMIES-1:0] spawn,
    output logic [NUM_ENEMIES-1:0] flydown,
    output logic [2:0]             row,
    output logic                   rand_side,
    output logic [2:0]             difficulty,
    output logic [3:0]             wave,
    output logic [7:0]             kills,
    output logic [2:0]             state_out
);

    // Counter widths; the spawn timer must also hold the accelerated floor of 8.
    localparam int PW  = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam int SGW = $clog2(((SPAWN_GAP > 8) ? SPAWN_GAP : 8) + 1);
    localparam int DW  = $clog2(DIVE_PERIOD + 1);
    localparam int CW  = $clog2(CLEAR_PAUSE + 1);
    localparam int SCW = $clog2(WAVE_SIZE + 1);

    localparam logic [DW-1:0]  DIVE_M1  = DW'(DIVE_PERIOD - 1);
    localparam logic [CW-1:0]  CLEAR_M1 = CW'(CLEAR_PAUSE - 1);
    localparam logic [SCW-1:0] WS       = SCW'(WAVE_SIZE);
    localparam logic [2:0]     ROW_LAST = 3'(NUM_ROWS - 1);
    localparam logic [PW:0]    NE       = (PW+1)'(NUM_ENEMIES);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SPAWNING   = 3'd1,
        ST_WAVE_CLEAR = 3'd2,
        ST_GAME_OVER  = 3'd3
    } state_t;

    state_t                 state_q, state_nxt;
    logic [SGW-1:0]         spawn_tmr;
    logic [SGW-1:0]         gap_m1;
    logic [DW-1:0]          dive_tmr;
    logic [CW-1:0]          clr_tmr;
    logic [SCW-1:0]         spawned_cnt;
    logic [2:0]             row_ptr;
    logic [PW-1:0]          dive_ptr, dive_ptr_nxt;
    logic [NUM_ENEMIES-1:0] pend_d2;
    logic [NUM_ENEMIES-1:0] pending;
    logic [7:0]             lfsr;
    logic [NUM_ENEMIES-1:0] expl_prev;

    logic [NUM_ENEMIES-1:0] free_sel, dive_sel;
    logic                   free_found, dive_found;
    logic [3:0]             rise_cnt;
    logic [8:0]             ksum;
    logic [3:0]             wave_inc;

    logic spawn_hit, dive_hit, clr_done, wave_done, active;
    logic spawn_fire, fly_fire, count_kills, restart, clear_exit;

    // Difficulty tier for a given wave number.
    function automatic logic [2:0] diff_for(input logic [3:0] w);
        if (w <= 4'd1)      return 3'b001;
        else if (w <= 4'd3) return 3'b010;
        else                return 3'b100;
    endfunction

    // A slot stays pending for the spawn frame and the one after, until the enemy reports itself.
    assign pending = spawn | pend_d2;

    assign spawn_hit   = (state_q == ST_SPAWNING) && (spawn_tmr == gap_m1);
    assign dive_hit    = (state_q == ST_SPAWNING) && (dive_tmr == DIVE_M1);
    assign clr_done    = (state_q == ST_WAVE_CLEAR) && (clr_tmr == CLEAR_M1);
    assign wave_done   = (spawned_cnt == WS) && (enemy_exists == '0) && (pending == '0);
    assign active      = (state_q == ST_SPAWNING) && !player_dead;
    assign spawn_fire  = active && spawn_hit && (spawned_cnt < WS) && free_found;
    assign fly_fire    = active && dive_hit && dive_found;
    assign count_kills = (state_q == ST_SPAWNING) || (state_q == ST_WAVE_CLEAR);
    assign restart     = (state_q == ST_GAME_OVER) && start && !player_dead;
    assign clear_exit  = clr_done && !player_dead;
    assign wave_inc    = (wave == 4'd15) ? wave : wave + 4'd1;
    assign state_out   = state_q;

`ifdef SPAWN_ACCEL_EN
    // Accelerated gap: SPAWN_GAP - 4*wave, floored at 8 frames.
    function automatic logic [SGW-1:0] gap_for(input logic [3:0] w);
        int g;
        g = SPAWN_GAP - 4 * int'(w);
        if (g < 8) g = 8;
        return SGW'(g);
    endfunction

    logic [SGW-1:0] gap_q;

    // Spawn gap is re-evaluated only when a new wave (or a new game) begins.
    always_ff @(posedge frame_clk) begin
        if (Reset)           gap_q <= gap_for(4'd0);
        else if (clear_exit) gap_q <= gap_for(wave_inc);
        else if (restart)    gap_q <= gap_for(4'd0);
    end

    assign gap_m1 = gap_q - 1'b1;
`else
    assign gap_m1 = SGW'(SPAWN_GAP - 1);
`endif

    // Game state register.
    always_ff @(posedge frame_clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    // Next-state decode; player death outranks wave completion and clear expiry.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_nxt = ST_SPAWNING;
            end
            ST_SPAWNING: begin
                if (player_dead)    state_nxt = ST_GAME_OVER;
                else if (wave_done) state_nxt = ST_WAVE_CLEAR;
            end
            ST_WAVE_CLEAR: begin
                if (player_dead)   state_nxt = ST_GAME_OVER;
                else if (clr_done) state_nxt = ST_SPAWNING;
            end
            ST_GAME_OVER: begin
                if (restart) state_nxt = ST_SPAWNING;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Lowest-index slot that is neither alive nor freshly spawned.
    always_comb begin
        free_sel   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (!free_found && !enemy_exists[i] && !pending[i]) begin
                free_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    // Round-robin dive pick starting at dive_ptr: first live, non-exploding slot.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        dive_sel     = '0;
        dive_found   = 1'b0;
        dive_ptr_nxt = dive_ptr;
        sum          = '0;
        idx          = '0;
        for (int k = 0; k < NUM_ENEMIES; k++) begin
            sum = {1'b0, dive_ptr} + (PW+1)'(k);
            if (sum >= NE) sum = sum - NE;
            idx = sum[PW-1:0];
            if (!dive_found && enemy_exists[idx] && !enemy_explosion[idx]) begin
                dive_sel[idx] = 1'b1;
                dive_found    = 1'b1;
                sum           = sum + 1'b1;
                dive_ptr_nxt  = (sum == NE) ? '0 : sum[PW-1:0];
            end
        end
    end

    // Number of explosion rising edges this frame, and the saturating kill sum.
    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            rise_cnt = rise_cnt + 4'(enemy_explosion[i] & ~expl_prev[i]);
        end
        ksum = {1'b0, kills} + 9'(rise_cnt);
    end

    // Frame timers: run only in their own state and sit at zero otherwise.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            spawn_tmr <= '0;
            dive_tmr  <= '0;
            clr_tmr   <= '0;
        end else begin
            if (state_q == ST_SPAWNING) begin
                spawn_tmr <= spawn_hit ? '0 : spawn_tmr + 1'b1;
                dive_tmr  <= dive_hit  ? '0 : dive_tmr + 1'b1;
            end else begin
                spawn_tmr <= '0;
                dive_tmr  <= '0;
            end
            if (state_q == ST_WAVE_CLEAR) clr_tmr <= clr_tmr + 1'b1;
            else                          clr_tmr <= '0;
        end
    end

    // Spawn/dive pulses, spawn attributes, pointers and the pending history.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            spawn       <= '0;
            flydown     <= '0;
            row         <= '0;
            rand_side   <= 1'b0;
            row_ptr     <= '0;
            dive_ptr    <= '0;
            spawned_cnt <= '0;
            pend_d2     <= '0;
        end else begin
            spawn   <= spawn_fire ? free_sel : '0;
            flydown <= fly_fire ? dive_sel : '0;
            pend_d2 <= spawn;
            if (spawn_fire) begin
                row       <= row_ptr;
                rand_side <= lfsr[0];
                row_ptr   <= (row_ptr == ROW_LAST) ? 3'd0 : row_ptr + 3'd1;
            end
            if (fly_fire) dive_ptr <= dive_ptr_nxt;
            if (clear_exit || restart) spawned_cnt <= '0;
            else if (spawn_fire)       spawned_cnt <= spawned_cnt + 1'b1;
        end
    end

    // Wave number, difficulty tier and kill count.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            wave       <= '0;
            difficulty <= 3'b001;
            kills      <= '0;
        end else begin
            if (clear_exit) begin
                wave       <= wave_inc;
                difficulty <= diff_for(wave_inc);
            end else if (restart) begin
                wave       <= '0;
                difficulty <= 3'b001;
            end
            if (restart)          kills <= '0;
            else if (count_kills) kills <= ksum[8] ? 8'hFF : ksum[7:0];
        end
    end

    // Side LFSR (taps 8,6,5,4) and explosion edge history.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            lfsr      <= LFSR_SEED;
            expl_prev <= '0;
        end else begin
            if (state_q != ST_IDLE) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            expl_prev <= enemy_explosion;
        end
    end

endmodule
